res_st_pool: RTL and testbench

Parametrised reservation-station pool: successor of the fixed 4-read-port reservation station in the Qu core. It accepts renamed uops from the front end and tracks operand readiness via tag wakeup broadcasts. Up to NUM_ISSUE ready entries are offered per cycle to back-end execution ports through valid/ready handshakes. Entry allocation, freeing, flush and occupancy accounting are internal, so the front end no longer supplies write addresses.

---
 rtl/res_st_pool_if.sv | 53 +++++
 rtl/res_st_pool.sv | 179 +++++++++++++++++
 tb/tb_res_st_pool.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/res_st_pool_if.sv
// Handshake bundle between the reservation-station pool and its front end / execution ports.
// The master side drives allocation, wakeup, flush and issue acceptance; the pool is the slave.
interface res_st_pool_if #(
    parameter int DEPTH             = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int PHY_RF_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH         = PHY_RF_ADDR_WIDTH,
    parameter int PAYLOAD_WIDTH     = 64,
    parameter int NUM_ISSUE         = 4,
    parameter int NUM_WAKEUP        = 2
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                                       flush;
    logic                                       alloc_valid;
    logic                                       alloc_ready;
    logic [PAYLOAD_WIDTH-1:0]                   alloc_payload;
    logic [TAG_WIDTH-1:0]                       alloc_rs1_tag;
    logic [TAG_WIDTH-1:0]                       alloc_rs2_tag;
    logic                                       alloc_rs1_rdy;
    logic                                       alloc_rs2_rdy;
    logic [DATA_WIDTH-1:0]                      alloc_rs1_data;
    logic [DATA_WIDTH-1:0]                      alloc_rs2_data;
    logic [NUM_WAKEUP-1:0]                      wakeup_valid;
    logic [NUM_WAKEUP-1:0][TAG_WIDTH-1:0]       wakeup_tag;
    logic [NUM_WAKEUP-1:0][DATA_WIDTH-1:0]      wakeup_data;
    logic [NUM_ISSUE-1:0]                       issue_valid;
    logic [NUM_ISSUE-1:0]                       issue_ready;
    logic [NUM_ISSUE-1:0][PAYLOAD_WIDTH-1:0]    issue_payload;
    logic [NUM_ISSUE-1:0][DATA_WIDTH-1:0]       issue_rs1_data;
    logic [NUM_ISSUE-1:0][DATA_WIDTH-1:0]       issue_rs2_data;
    logic [NUM_ISSUE-1:0][IDX_W-1:0]            issue_idx;
    logic [CNT_W-1:0]                           count;
    logic                                       full;
    logic                                       empty;

    modport master (
        output flush, alloc_valid, alloc_payload, alloc_rs1_tag, alloc_rs2_tag,
               alloc_rs1_rdy, alloc_rs2_rdy, alloc_rs1_data, alloc_rs2_data,
               wakeup_valid, wakeup_tag, wakeup_data, issue_ready,
        input  alloc_ready, issue_valid, issue_payload, issue_rs1_data, issue_rs2_data,
               issue_idx, count, full, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_payload, alloc_rs1_tag, alloc_rs2_tag,
               alloc_rs1_rdy, alloc_rs2_rdy, alloc_rs1_data, alloc_rs2_data,
               wakeup_valid, wakeup_tag, wakeup_data, issue_ready,
        output alloc_ready, issue_valid, issue_payload, issue_rs1_data, issue_rs2_data,
               issue_idx, count, full, empty
    );
endinterface

// File: rtl/res_st_pool.sv
// Reservation-station pool: internal allocation, tag wakeup with alloc bypass, and
// in-order selection of the lowest-index ready entries onto NUM_ISSUE issue ports.
module res_st_pool #(
    parameter int DEPTH             = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int PHY_RF_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH         = PHY_RF_ADDR_WIDTH,
    parameter int PAYLOAD_WIDTH     = 64,
    parameter int NUM_ISSUE         = 4,
    parameter int NUM_WAKEUP        = 2
) (
    input logic          clk,
    input logic          rst,
    res_st_pool_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0]         rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0]         rs2_rdy_q, rs2_rdy_d;
    logic [TAG_WIDTH-1:0]     rs1_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]     rs1_tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]     rs2_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]     rs2_tag_d [DEPTH];
    logic [DATA_WIDTH-1:0]    rs1_data_q [DEPTH];
    logic [DATA_WIDTH-1:0]    rs1_data_d [DEPTH];
    logic [DATA_WIDTH-1:0]    rs2_data_q [DEPTH];
    logic [DATA_WIDTH-1:0]    rs2_data_d [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] payload_d [DEPTH];
    logic [CNT_W-1:0]         count_q, count_d;

    logic [DEPTH-1:0]                  ready_vec, free_vec, free_slots, alloc_onehot;
    logic [NUM_ISSUE-1:0][DEPTH-1:0]   sel_onehot;
    logic [NUM_ISSUE-1:0][IDX_W-1:0]   sel_idx;
    logic [NUM_ISSUE-1:0]              sel_valid, issue_valid_w, issue_fire;
    logic [CNT_W-1:0]                  fire_cnt;
    logic                              full_w, alloc_ready_w, alloc_fire;
    logic [DATA_WIDTH:0]               alloc_wk1, alloc_wk2;

    logic [NUM_WAKEUP-1:0]                 wk_valid;
    logic [NUM_WAKEUP-1:0][TAG_WIDTH-1:0]  wk_tag;
    logic [NUM_WAKEUP-1:0][DATA_WIDTH-1:0] wk_data;

    assign wk_valid = bus.wakeup_valid;
    assign wk_tag   = bus.wakeup_tag;
    assign wk_data  = bus.wakeup_data;

    // Returns {hit, data}; scanning downward lets the lowest matching port win.
    function automatic logic [DATA_WIDTH:0] wake_lookup(input logic [TAG_WIDTH-1:0] tag);
        logic [DATA_WIDTH:0] r;
        r = '0;
        for (int j = NUM_WAKEUP - 1; j >= 0; j--) begin
            if (wk_valid[j] && (wk_tag[j] == tag)) r = {1'b1, wk_data[j]};
        end
        return r;
    endfunction

    assign ready_vec     = valid_q & rs1_rdy_q & rs2_rdy_q;
    assign full_w        = (count_q == CNT_W'(DEPTH));
    assign alloc_ready_w = ~full_w & ~bus.flush;
    assign alloc_fire    = bus.alloc_valid & alloc_ready_w;
    assign free_slots    = ~valid_q;
    assign alloc_onehot  = alloc_fire ? (free_slots & (~free_slots + DEPTH'(1))) : '0;
    assign alloc_wk1     = wake_lookup(bus.alloc_rs1_tag);
    assign alloc_wk2     = wake_lookup(bus.alloc_rs2_tag);

    // Each port peels the lowest remaining ready bit, so ports never share an entry.
    always_comb begin
        logic [DEPTH-1:0] mask;
        mask       = ready_vec;
        sel_onehot = '0;
        sel_idx    = '0;
        sel_valid  = '0;
        for (int k = 0; k < NUM_ISSUE; k++) begin
            sel_onehot[k] = mask & (~mask + DEPTH'(1));
            sel_valid[k]  = |mask;
            mask          = mask & ~sel_onehot[k];
            for (int i = 0; i < DEPTH; i++) begin
                if (sel_onehot[k][i]) sel_idx[k] = IDX_W'(i);
            end
        end
    end

    assign issue_valid_w = sel_valid & {NUM_ISSUE{~bus.flush}};
    assign issue_fire    = issue_valid_w & bus.issue_ready;

    generate
        for (genvar gi = 0; gi < NUM_ISSUE; gi++) begin : g_issue
            assign bus.issue_payload[gi]  = payload_q[sel_idx[gi]];
            assign bus.issue_rs1_data[gi] = rs1_data_q[sel_idx[gi]];
            assign bus.issue_rs2_data[gi] = rs2_data_q[sel_idx[gi]];
            assign bus.issue_idx[gi]      = sel_idx[gi];
        end
    endgenerate

    always_comb begin
        free_vec = '0;
        fire_cnt = '0;
        for (int k = 0; k < NUM_ISSUE; k++) begin
            if (issue_fire[k]) begin
                free_vec = free_vec | sel_onehot[k];
                fire_cnt = fire_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        logic [DATA_WIDTH:0] wk1, wk2;
        wk1        = '0;
        wk2        = '0;
        valid_d    = valid_q & ~free_vec;
        rs1_rdy_d  = rs1_rdy_q;
        rs2_rdy_d  = rs2_rdy_q;
        rs1_tag_d  = rs1_tag_q;
        rs2_tag_d  = rs2_tag_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        payload_d  = payload_q;
        count_d    = count_q + CNT_W'(alloc_fire) - fire_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            wk1 = wake_lookup(rs1_tag_q[i]);
            wk2 = wake_lookup(rs2_tag_q[i]);
            if (valid_q[i] && !rs1_rdy_q[i] && wk1[DATA_WIDTH]) begin
                rs1_rdy_d[i]  = 1'b1;
                rs1_data_d[i] = wk1[DATA_WIDTH-1:0];
            end
            if (valid_q[i] && !rs2_rdy_q[i] && wk2[DATA_WIDTH]) begin
                rs2_rdy_d[i]  = 1'b1;
                rs2_data_d[i] = wk2[DATA_WIDTH-1:0];
            end
            // A non-ready source whose producer broadcasts this same cycle is captured directly.
            if (alloc_onehot[i]) begin
                valid_d[i]    = 1'b1;
                payload_d[i]  = bus.alloc_payload;
                rs1_tag_d[i]  = bus.alloc_rs1_tag;
                rs2_tag_d[i]  = bus.alloc_rs2_tag;
                rs1_rdy_d[i]  = bus.alloc_rs1_rdy | alloc_wk1[DATA_WIDTH];
                rs2_rdy_d[i]  = bus.alloc_rs2_rdy | alloc_wk2[DATA_WIDTH];
                rs1_data_d[i] = bus.alloc_rs1_rdy ? bus.alloc_rs1_data : alloc_wk1[DATA_WIDTH-1:0];
                rs2_data_d[i] = bus.alloc_rs2_rdy ? bus.alloc_rs2_data : alloc_wk2[DATA_WIDTH-1:0];
            end
        end
        if (bus.flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            count_q   <= count_d;
        end
    end

    // Payload, tags and operands are qualified by valid/rdy, so they need no reset.
    always_ff @(posedge clk) begin
        payload_q  <= payload_d;
        rs1_tag_q  <= rs1_tag_d;
        rs2_tag_q  <= rs2_tag_d;
        rs1_data_q <= rs1_data_d;
        rs2_data_q <= rs2_data_d;
    end

    assign bus.issue_valid = issue_valid_w;
    assign bus.alloc_ready = alloc_ready_w;
    assign bus.count       = count_q;
    assign bus.full        = full_w;
    assign bus.empty       = (count_q == '0);
endmodule

// File: tb/tb_res_st_pool.sv
// Scoreboarded bench for res_st_pool: directed scenarios followed by random traffic,
// all checked against an entry-list reference model.
module tb_res_st_pool;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int PW    = 64;
    localparam int NI    = 4;
    localparam int NW    = 2;
    localparam int IW    = 4;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    res_st_pool_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PHY_RF_ADDR_WIDTH(TW), .TAG_WIDTH(TW),
                     .PAYLOAD_WIDTH(PW), .NUM_ISSUE(NI), .NUM_WAKEUP(NW)) bus ();

    res_st_pool #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PHY_RF_ADDR_WIDTH(TW), .TAG_WIDTH(TW),
                  .PAYLOAD_WIDTH(PW), .NUM_ISSUE(NI), .NUM_WAKEUP(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic                     flush;
        logic                     av;
        logic [PW-1:0]            pay;
        logic [TW-1:0]            t1;
        logic [TW-1:0]            t2;
        logic                     r1;
        logic                     r2;
        logic [DW-1:0]            d1;
        logic [DW-1:0]            d2;
        logic [NW-1:0]            wv;
        logic [NW-1:0][TW-1:0]    wt;
        logic [NW-1:0][DW-1:0]    wd;
        logic [NI-1:0]            ir;
    } stim_t;

    typedef struct packed {
        logic [NI-1:0]            iv;
        logic [NI-1:0][IW-1:0]    idx;
        logic [NI-1:0][PW-1:0]    pay;
        logic [NI-1:0][DW-1:0]    d1;
        logic [NI-1:0][DW-1:0]    d2;
        logic                     ar;
        logic                     full;
        logic                     empty;
        logic [CW-1:0]            cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: one record per slot, plain arrays.
    bit            m_valid [DEPTH];
    bit            m_r1    [DEPTH];
    bit            m_r2    [DEPTH];
    logic [TW-1:0] m_t1    [DEPTH];
    logic [TW-1:0] m_t2    [DEPTH];
    logic [DW-1:0] m_d1    [DEPTH];
    logic [DW-1:0] m_d2    [DEPTH];
    logic [PW-1:0] m_pay   [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, want);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit lookup(input stim_t s, input logic [TW-1:0] tag, output logic [DW-1:0] d);
        d = '0;
        for (int j = 0; j < NW; j++) begin
            if (s.wv[j] && s.wt[j] == tag) begin
                d = s.wd[j];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic drive(input stim_t s);
        bus.flush          = s.flush;
        bus.alloc_valid    = s.av;
        bus.alloc_payload  = s.pay;
        bus.alloc_rs1_tag  = s.t1;
        bus.alloc_rs2_tag  = s.t2;
        bus.alloc_rs1_rdy  = s.r1;
        bus.alloc_rs2_rdy  = s.r2;
        bus.alloc_rs1_data = s.d1;
        bus.alloc_rs2_data = s.d2;
        bus.wakeup_valid   = s.wv;
        bus.wakeup_tag     = s.wt;
        bus.wakeup_data    = s.wd;
        bus.issue_ready    = s.ir;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_r1[i]    = 0;
            m_r2[i]    = 0;
        end
    endtask

    // Drive one cycle, queue what the DUT must show during it, then advance the model past the edge.
    task automatic cycle(input stim_t s);
        exp_t          e;
        int            rl[$];
        int            occ;
        int            slot;
        logic [DW-1:0] d;
        @(negedge clk);
        drive(s);
        e   = '0;
        occ = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i]) occ++;
            if (m_valid[i] && m_r1[i] && m_r2[i]) rl.push_back(i);
        end
        for (int k = 0; k < NI; k++) begin
            if (!s.flush && k < rl.size()) begin
                e.iv[k]  = 1'b1;
                e.idx[k] = IW'(rl[k]);
                e.pay[k] = m_pay[rl[k]];
                e.d1[k]  = m_d1[rl[k]];
                e.d2[k]  = m_d2[rl[k]];
            end
        end
        e.ar    = !s.flush && (occ < DEPTH);
        e.full  = (occ == DEPTH);
        e.empty = (occ == 0);
        e.cnt   = CW'(occ);
        exp_q.push_back(e);

        if (s.flush) begin
            model_clear();
        end else begin
            slot = -1;
            for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && slot < 0) slot = i;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i]) begin
                    if (!m_r1[i] && lookup(s, m_t1[i], d)) begin m_r1[i] = 1; m_d1[i] = d; end
                    if (!m_r2[i] && lookup(s, m_t2[i], d)) begin m_r2[i] = 1; m_d2[i] = d; end
                end
            end
            for (int k = 0; k < NI; k++) if (e.iv[k] && s.ir[k]) m_valid[rl[k]] = 0;
            if (s.av && e.ar) begin
                m_valid[slot] = 1;
                m_pay[slot]   = s.pay;
                m_t1[slot]    = s.t1;
                m_t2[slot]    = s.t2;
                m_r1[slot]    = s.r1;
                m_r2[slot]    = s.r2;
                m_d1[slot]    = s.d1;
                m_d2[slot]    = s.d2;
                if (!s.r1 && lookup(s, s.t1, d)) begin m_r1[slot] = 1; m_d1[slot] = d; end
                if (!s.r2 && lookup(s, s.t2, d)) begin m_r2[slot] = 1; m_d2[slot] = d; end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(idle());
        #3 rst = 1'b0;
        #1;
        check("rst_issue_valid", bus.issue_valid, '0);
        check("rst_count", bus.count, '0);
        check("rst_empty", bus.empty, 1'b1);
        model_clear();
        @(negedge clk);
        #3 rst = 1'b1;
    endtask

    // Monitor: pops one expectation per cycle, compares once outputs have settled.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("alloc_ready", bus.alloc_ready, e.ar);
                check("count", bus.count, e.cnt);
                check("full", bus.full, e.full);
                check("empty", bus.empty, e.empty);
                check("issue_valid", bus.issue_valid, e.iv);
                for (int k = 0; k < NI; k++) begin
                    if (e.iv[k]) begin
                        check($sformatf("port%0d_idx", k), bus.issue_idx[k], e.idx[k]);
                        check($sformatf("port%0d_payload", k), bus.issue_payload[k], e.pay[k]);
                        check($sformatf("port%0d_rs1", k), bus.issue_rs1_data[k], e.d1[k]);
                        check($sformatf("port%0d_rs2", k), bus.issue_rs2_data[k], e.d2[k]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        stim_t s;
        model_clear();
        drive(idle());
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;

        // Three fully ready uops, then drain them in one cycle.
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.av = 1; s.r1 = 1; s.r2 = 1;
            s.pay = 64'(100 + i); s.d1 = 32'(i); s.d2 = 32'(10 + i);
            cycle(s);
        end
        s = idle(); s.ir = '1; cycle(s);
        cycle(idle());

        // Fill with rs1 waiting on tag 5, try one extra, wake tag 5, issue under full.
        for (int i = 0; i < DEPTH; i++) begin
            s = idle(); s.av = 1; s.t1 = 6'd5; s.r2 = 1; s.d2 = 32'(i); s.pay = 64'(200 + i);
            cycle(s);
        end
        s = idle(); s.av = 1; s.r1 = 1; s.r2 = 1; cycle(s);
        s = idle(); s.wv = 2'b01; s.wt[0] = 6'd5; s.wd[0] = 32'hDEADBEEF; cycle(s);
        s = idle(); s.av = 1; s.r1 = 1; s.r2 = 1; s.ir = 4'b0001; cycle(s);
        cycle(idle());
        repeat (5) begin s = idle(); s.ir = '1; cycle(s); end

        // Alloc bypass on wakeup port 1.
        s = idle(); s.av = 1; s.r1 = 1; s.d1 = 32'h55; s.t2 = 6'd9; s.pay = 64'h77;
        s.wv = 2'b10; s.wt[1] = 6'd9; s.wd[1] = 32'h1234; cycle(s);
        s = idle(); s.ir = '1; cycle(s);

        // Two ports broadcast the same tag: lower port's data is taken.
        s = idle(); s.av = 1; s.t1 = 6'd7; s.r2 = 1; s.pay = 64'h88; cycle(s);
        s = idle(); s.wv = 2'b11; s.wt[0] = 6'd7; s.wt[1] = 6'd7; s.wd[0] = 32'hA; s.wd[1] = 32'hB; cycle(s);
        s = idle(); s.ir = '1; cycle(s);
        cycle(idle());

        // Flush with eight occupied entries and a concurrent alloc.
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.av = 1; s.t1 = 6'd3; s.r2 = 1; cycle(s);
        end
        s = idle(); s.flush = 1; s.av = 1; s.r1 = 1; s.r2 = 1; s.ir = '1; cycle(s);
        cycle(idle());

        // Random traffic with occasional mid-operation resets.
        for (int n = 0; n < 2000; n++) begin
            if (n % 500 == 250) do_reset();
            s = idle();
            s.flush = ($urandom_range(0, 59) == 0);
            s.av    = ($urandom_range(0, 9) < 7);
            s.pay   = {$urandom, $urandom};
            s.t1    = TW'($urandom_range(0, 7));
            s.t2    = TW'($urandom_range(0, 7));
            s.r1    = 1'($urandom_range(0, 1));
            s.r2    = 1'($urandom_range(0, 1));
            s.d1    = $urandom;
            s.d2    = $urandom;
            for (int j = 0; j < NW; j++) begin
                s.wv[j] = 1'($urandom_range(0, 1));
                s.wt[j] = TW'($urandom_range(0, 7));
                s.wd[j] = $urandom;
            end
            s.ir = NI'($urandom_range(0, 15));
            cycle(s);
        end
        cycle(idle());

        @(negedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
